// File: rtl/reg_file_scoreboard_pkg.sv
// Shared sizing constants for the register file and its scoreboard.
// Latency: n/a (constants only).
// Backpressure: n/a.
package reg_file_scoreboard_pkg;
   localparam int DATA_W = 32;
   localparam int NREG   = 32;
   localparam int ADDR_W = 5;
   localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/reg_file_scoreboard_decoder.sv
// 5-to-32 one-hot decoder used to form per-register enables.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows the select every cycle.
module fiveToThirtyTwoDecoder
   import reg_file_scoreboard_pkg::*;
(
   input  logic [ADDR_W-1:0] sel,
   output logic [NREG-1:0]   onehot
);

   // exactly one bit set, at the selected index
   always_comb begin
      onehot      = '0;
      onehot[sel] = 1'b1;
   end

endmodule

// File: rtl/reg_file_scoreboard.sv
// 32x32 register file, two bypassed read ports, one write port, pending-write scoreboard.
// Latency: reads and busy flags combinational; writes and scoreboard updates land at the next edge.
// Backpressure: none internally; rs_busy/rt_busy tell decode to stall on a RAW hazard.
module reg_file_scoreboard
   import reg_file_scoreboard_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_dst,
   output logic              rs_busy,
   output logic              rt_busy,
   output logic [NREG-1:0]   busy_vec
);

   // register 0 is hardwired: never written, never marked busy
   localparam logic [NREG-1:0] R0_MASK = {{(NREG-1){1'b1}}, 1'b0};

   logic [DATA_W-1:0] regs [NREG];
   logic [NREG-1:0]   busy;
   logic [NREG-1:0]   wb_dec;
   logic [NREG-1:0]   iss_dec;
   logic [NREG-1:0]   we;
   logic [NREG-1:0]   set_vec;
   logic              rs_wb_hit;
   logic              rt_wb_hit;

   fiveToThirtyTwoDecoder u_wb_dec (
      .sel    (wb_addr),
      .onehot (wb_dec)
   );

   fiveToThirtyTwoDecoder u_iss_dec (
      .sel    (iss_dst),
      .onehot (iss_dec)
   );

   assign we      = wb_dec  & {NREG{wb_en}}  & R0_MASK;
   assign set_vec = iss_dec & {NREG{iss_en}} & R0_MASK;

   // storage and scoreboard update; a new producer's set beats a retiring write's clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
         busy <= '0;
      end else begin
         for (int i = 1; i < NREG; i++) begin
            if (we[i]) begin
               regs[i] <= wb_data;
            end
         end
         busy <= (set_vec | (busy & ~we)) & R0_MASK;
      end
   end

   // read ports with same-cycle writeback bypass and hazard flags
   always_comb begin
      rs_wb_hit = wb_en && (wb_addr == rs_addr);
      rt_wb_hit = wb_en && (wb_addr == rt_addr);

      if (rs_addr == ZERO_REG) begin
         rs_data = '0;
      end else if (rs_wb_hit) begin
         rs_data = wb_data;
      end else begin
         rs_data = regs[rs_addr];
      end

      if (rt_addr == ZERO_REG) begin
         rt_data = '0;
      end else if (rt_wb_hit) begin
         rt_data = wb_data;
      end else begin
         rt_data = regs[rt_addr];
      end

      rs_busy  = busy[rs_addr] && !rs_wb_hit && (rs_addr != ZERO_REG);
      rt_busy  = busy[rt_addr] && !rt_wb_hit && (rt_addr != ZERO_REG);
      busy_vec = busy;
   end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Bench for reg_file_scoreboard: directed scenarios then random traffic against an array model.
// Latency: model expects zero-cycle reads and one-edge write/scoreboard updates.
// Backpressure: n/a.
module tb_reg_file_scoreboard;

   logic        clk;
   logic        rst_n;
   logic [4:0]  rs_addr, rt_addr, wb_addr, iss_dst;
   logic [31:0] rs_data, rt_data, wb_data;
   logic        wb_en, iss_en;
   logic        rs_busy, rt_busy;
   logic [31:0] busy_vec;

   int tests = 0;
   int fails = 0;

   // reference model: plain arrays holding architectural state
   logic [31:0] mreg  [32];
   bit          mbusy [32];

   reg_file_scoreboard dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rs_addr  (rs_addr),
      .rt_addr  (rt_addr),
      .rs_data  (rs_data),
      .rt_data  (rt_data),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .iss_en   (iss_en),
      .iss_dst  (iss_dst),
      .rs_busy  (rs_busy),
      .rt_busy  (rt_busy),
      .busy_vec (busy_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (wb_en && wb_addr == a) return wb_data;
      return mreg[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      return mbusy[a] && !(wb_en && wb_addr == a);
   endfunction

   function automatic logic [31:0] exp_vec();
      logic [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = mbusy[i];
      return v;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, "_rs_data"},  rs_data,          exp_read(rs_addr));
      chk({tag, "_rt_data"},  rt_data,          exp_read(rt_addr));
      chk({tag, "_rs_busy"},  {31'd0, rs_busy}, {31'd0, exp_busy(rs_addr)});
      chk({tag, "_rt_busy"},  {31'd0, rt_busy}, {31'd0, exp_busy(rt_addr)});
      chk({tag, "_busy_vec"}, busy_vec,         exp_vec());
   endtask

   // inputs are already driven; settle, optionally check, then clock and advance the model
   task automatic step(input string tag, input bit do_check);
      #2;
      if (do_check) check_all(tag);
      @(posedge clk);
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            mreg[i]  = 32'd0;
            mbusy[i] = 1'b0;
         end
      end else begin
         if (wb_en && wb_addr != 5'd0) begin
            mreg[wb_addr]  = wb_data;
            mbusy[wb_addr] = 1'b0;
         end
         if (iss_en && iss_dst != 5'd0) mbusy[iss_dst] = 1'b1;
      end
      #1;
   endtask

   task automatic idle();
      rst_n = 1'b1; wb_en = 1'b0; iss_en = 1'b0;
      wb_addr = 5'd0; wb_data = 32'd0; iss_dst = 5'd0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         mreg[i]  = 32'd0;
         mbusy[i] = 1'b0;
      end
      idle();
      rs_addr = 5'd0; rt_addr = 5'd0;
      @(negedge clk);

      // 1: reset, then all addresses read zero
      rst_n = 1'b0;
      step("reset", 1'b0);
      rst_n = 1'b1;
      chk("t1_busy_vec_after_reset", busy_vec, 32'd0);
      for (int a = 0; a < 32; a++) begin
         rs_addr = 5'(a); rt_addr = 5'(31 - a);
         #1;
         chk("t1_rs_zero", rs_data, 32'd0);
         chk("t1_rt_zero", rt_data, 32'd0);
      end

      // 2: bypass, then read from storage
      wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF; rs_addr = 5'd5; rt_addr = 5'd0;
      #2;
      chk("t2_bypass", rs_data, 32'hDEADBEEF);
      step("t2a", 1'b1);
      idle();
      #2;
      chk("t2_storage", rs_data, 32'hDEADBEEF);
      step("t2b", 1'b1);

      // 3: register 0 ignores writes and issues
      wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF; iss_en = 1'b1; iss_dst = 5'd0;
      rs_addr = 5'd0;
      step("t3a", 1'b1);
      idle();
      #2;
      chk("t3_r0_read", rs_data, 32'd0);
      chk("t3_r0_busy", {31'd0, busy_vec[0]}, 32'd0);
      step("t3b", 1'b1);

      // 4: issue marks busy, writeback clears and bypasses
      iss_en = 1'b1; iss_dst = 5'd7;
      step("t4a", 1'b1);
      idle(); rs_addr = 5'd7;
      #2;
      chk("t4_vec7_set", {31'd0, busy_vec[7]}, 32'd1);
      chk("t4_rs_busy", {31'd0, rs_busy}, 32'd1);
      wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h12;
      #1;
      chk("t4_rs_busy_masked", {31'd0, rs_busy}, 32'd0);
      chk("t4_rs_bypass", rs_data, 32'h12);
      step("t4b", 1'b1);
      idle();
      #2;
      chk("t4_vec7_clear", {31'd0, busy_vec[7]}, 32'd0);
      step("t4c", 1'b1);

      // 5: set beats clear on the same register
      iss_en = 1'b1; iss_dst = 5'd9;
      step("t5a", 1'b1);
      iss_en = 1'b1; iss_dst = 5'd9; wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h0BADF00D;
      step("t5b", 1'b1);
      idle(); rs_addr = 5'd9;
      #2;
      chk("t5_set_wins", {31'd0, busy_vec[9]}, 32'd1);
      chk("t5_reg9", rs_data, 32'h0BADF00D);
      step("t5c", 1'b1);

      // 6: mid-operation reset discards state; a writeback during reset is dropped
      wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hA5A5A5A5; iss_en = 1'b1; iss_dst = 5'd3;
      step("t6a", 1'b1);
      rst_n = 1'b0; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h11111111; iss_en = 1'b1; iss_dst = 5'd4;
      step("t6b", 1'b1);
      idle(); rs_addr = 5'd3; rt_addr = 5'd4;
      #2;
      chk("t6_reg3_reset", rs_data, 32'd0);
      chk("t6_vec_reset", busy_vec, 32'd0);
      step("t6c", 1'b1);

      // random traffic, reads biased toward the writeback/issue addresses
      for (int n = 0; n < 400; n++) begin
         rst_n   = ($urandom_range(0, 63) != 0);
         wb_en   = $urandom_range(0, 1) == 1;
         wb_addr = 5'($urandom_range(0, 31));
         wb_data = $urandom;
         iss_en  = $urandom_range(0, 1) == 1;
         iss_dst = 5'($urandom_range(0, 31));
         case ($urandom_range(0, 3))
            0: rs_addr = wb_addr;
            1: rs_addr = iss_dst;
            default: rs_addr = 5'($urandom_range(0, 31));
         endcase
         rt_addr = ($urandom_range(0, 3) == 0) ? rs_addr : 5'($urandom_range(0, 31));
         step("rand", 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
